// File: rtl/aes_axi_pkg.sv
// Shared types and AXI encodings for the AES256 AXI4 burst master.
package aes_axi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_AR,
        S_R,
        S_DONE
    } state_e;

    localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/aes_axi_burst_master.sv
// Command-driven AXI4 master issuing one INCR burst (1-256 beats) at a time.
// Optional AES_AXIM_RLAST_CHECK_EN: flag rlast/beat-count disagreement as an error.
module aes_axi_burst_master
    import aes_axi_pkg::*;
#(
    parameter int                  ADDR_WIDTH = 6,
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ID_WIDTH   = 2,
    parameter logic [ID_WIDTH-1:0] AXI_ID     = 2'b11
) (
    input  logic                    m00_axi_aclk,
    input  logic                    m00_axi_aresetn,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]              cmd_len,

    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,

    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_last,
    output logic                    rd_valid,
    input  logic                    rd_ready,

    output logic                    done,
    output logic                    err,

    output logic [ADDR_WIDTH-1:0]   m00_axi_awaddr,
    output logic [7:0]              m00_axi_awlen,
    output logic [2:0]              m00_axi_awsize,
    output logic [1:0]              m00_axi_awburst,
    output logic [ID_WIDTH-1:0]     m00_axi_awid,
    output logic                    m00_axi_awvalid,
    input  logic                    m00_axi_awready,

    output logic [DATA_WIDTH-1:0]   m00_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m00_axi_wstrb,
    output logic                    m00_axi_wlast,
    output logic                    m00_axi_wvalid,
    input  logic                    m00_axi_wready,

    input  logic [1:0]              m00_axi_bresp,
    input  logic [ID_WIDTH-1:0]     m00_axi_bid,
    input  logic                    m00_axi_bvalid,
    output logic                    m00_axi_bready,

    output logic [ADDR_WIDTH-1:0]   m00_axi_araddr,
    output logic [7:0]              m00_axi_arlen,
    output logic [2:0]              m00_axi_arsize,
    output logic [1:0]              m00_axi_arburst,
    output logic                    m00_axi_arvalid,
    input  logic                    m00_axi_arready,

    input  logic [DATA_WIDTH-1:0]   m00_axi_rdata,
    input  logic [1:0]              m00_axi_rresp,
    input  logic                    m00_axi_rlast,
    input  logic                    m00_axi_rvalid,
    output logic                    m00_axi_rready
);

    state_e                  state, state_n;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              len_q;
    logic [7:0]              beat_cnt;
    logic                    err_acc;
    logic                    cmd_ready_q;
    logic                    awvalid_q;
    logic                    arvalid_q;
    logic                    last_beat;
    logic                    w_hs;
    logic                    r_hs;
    logic                    r_end;
    logic                    r_fault;

    assign last_beat = (beat_cnt == len_q);
    assign w_hs      = (state == S_W) && wr_valid && m00_axi_wready;
    assign r_hs      = (state == S_R) && m00_axi_rvalid && rd_ready;

`ifdef AES_AXIM_RLAST_CHECK_EN
    // An early rlast cuts the burst short; a missing rlast on the counted last beat does not.
    assign r_end   = last_beat || m00_axi_rlast;
    assign r_fault = last_beat ? !m00_axi_rlast : m00_axi_rlast;
`else
    logic unused_rlast;
    assign unused_rlast = m00_axi_rlast;
    assign r_end        = last_beat;
    assign r_fault      = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (cmd_valid && cmd_ready_q) state_n = cmd_write ? S_AW : S_AR;
            S_AW:   if (m00_axi_awready) state_n = S_W;
            S_W:    if (w_hs && last_beat) state_n = S_B;
            S_B:    if (m00_axi_bvalid) state_n = S_DONE;
            S_AR:   if (m00_axi_arready) state_n = S_R;
            S_R:    if (r_hs && r_end) state_n = S_DONE;
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Handshake-facing valids/ready are registered from the next state so
    // they never depend combinationally on the slave's ready inputs.
    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            state       <= S_IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            arvalid_q   <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            beat_cnt    <= '0;
            err_acc     <= 1'b0;
        end else begin
            state       <= state_n;
            cmd_ready_q <= (state_n == S_IDLE);
            awvalid_q   <= (state_n == S_AW);
            arvalid_q   <= (state_n == S_AR);
            if (state == S_IDLE && cmd_valid && cmd_ready_q) begin
                addr_q   <= cmd_addr;
                len_q    <= cmd_len;
                beat_cnt <= '0;
                err_acc  <= 1'b0;
            end
            if (w_hs || r_hs) beat_cnt <= beat_cnt + 8'd1;
            if (state == S_B && m00_axi_bvalid)
                err_acc <= err_acc | (m00_axi_bresp != AXI_RESP_OKAY) | (m00_axi_bid != AXI_ID);
            if (r_hs)
                err_acc <= err_acc | (m00_axi_rresp != AXI_RESP_OKAY) | r_fault;
        end
    end

    assign cmd_ready       = cmd_ready_q;

    assign m00_axi_awaddr  = addr_q;
    assign m00_axi_awlen   = len_q;
    assign m00_axi_awsize  = AXI_SIZE_4B;
    assign m00_axi_awburst = AXI_BURST_INCR;
    assign m00_axi_awid    = AXI_ID;
    assign m00_axi_awvalid = awvalid_q;

    assign m00_axi_wdata   = wr_data;
    assign m00_axi_wstrb   = '1;
    assign m00_axi_wlast   = last_beat;
    assign m00_axi_wvalid  = (state == S_W) && wr_valid;
    assign wr_ready        = (state == S_W) && m00_axi_wready;

    assign m00_axi_bready  = (state == S_B);

    assign m00_axi_araddr  = addr_q;
    assign m00_axi_arlen   = len_q;
    assign m00_axi_arsize  = AXI_SIZE_4B;
    assign m00_axi_arburst = AXI_BURST_INCR;
    assign m00_axi_arvalid = arvalid_q;

    assign rd_data         = m00_axi_rdata;
    assign rd_last         = last_beat;
    assign rd_valid        = (state == S_R) && m00_axi_rvalid;
    assign m00_axi_rready  = (state == S_R) && rd_ready;

    assign done            = (state == S_DONE);
    assign err             = (state == S_DONE) && err_acc;

endmodule

// File: tb/tb_aes_axi_burst_master.sv
// Randomized scoreboard bench for aes_axi_burst_master: the bench plays AXI slave,
// write source and read sink; a burst-level model predicts every beat and completion.
module tb_aes_axi_burst_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [5:0]  cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [31:0] wr_data = '0;
    logic        wr_valid = 1'b0, wr_ready;
    logic [31:0] rd_data;
    logic        rd_last, rd_valid, rd_ready = 1'b0;
    logic        done, err;
    logic [5:0]  awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, awid;
    logic        awvalid, awready = 1'b0, arvalid, arready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready = 1'b0;
    logic [1:0]  bresp = '0, bid = '0;
    logic        bvalid = 1'b0, bready;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b0, rvalid = 1'b0, rready;

    aes_axi_burst_master dut (
        .m00_axi_aclk(clk), .m00_axi_aresetn(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done(done), .err(err),
        .m00_axi_awaddr(awaddr), .m00_axi_awlen(awlen), .m00_axi_awsize(awsize),
        .m00_axi_awburst(awburst), .m00_axi_awid(awid), .m00_axi_awvalid(awvalid),
        .m00_axi_awready(awready),
        .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb), .m00_axi_wlast(wlast),
        .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
        .m00_axi_bresp(bresp), .m00_axi_bid(bid), .m00_axi_bvalid(bvalid), .m00_axi_bready(bready),
        .m00_axi_araddr(araddr), .m00_axi_arlen(arlen), .m00_axi_arsize(arsize),
        .m00_axi_arburst(arburst), .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
        .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rlast(rlast),
        .m00_axi_rvalid(rvalid), .m00_axi_rready(rready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = -10;
    int last_hs = -10;
    int done_cnt = 0;
    int w_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard queues (expected DUT behaviour) and slave-side stimulus queues.
    logic [14:0] exp_a_q[$];   // {write, addr, len}
    logic [32:0] exp_w_q[$];   // {wlast, wdata}
    logic [32:0] exp_rd_q[$];  // {rd_last, rd_data}
    logic        exp_done_q[$];
    logic [31:0] src_q[$];
    logic [3:0]  b_q[$];       // {bid, bresp}
    logic [34:0] r_q[$];       // {rlast, rresp, rdata}

    // Per-beat stimulus for the next command.
    logic [31:0] bd[256];
    logic [1:0]  br[256];
    logic        bl[256];
    logic [1:0]  g_bresp, g_bid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: predicts the burst from the command and the slave's responses.
    task automatic model(input logic wr, input logic [5:0] addr, input logic [7:0] len);
        logic e;
        e = 1'b0;
        exp_a_q.push_back({wr, addr, len});
        if (wr) begin
            for (int i = 0; i <= int'(len); i++) begin
                src_q.push_back(bd[i]);
                exp_w_q.push_back({i == int'(len), bd[i]});
            end
            b_q.push_back({g_bid, g_bresp});
            e = (g_bresp != 2'b00) || (g_bid != 2'b11);
        end else begin
            for (int i = 0; i <= int'(len); i++) begin
                if (br[i] != 2'b00) e = 1'b1;
                r_q.push_back({bl[i], br[i], bd[i]});
                exp_rd_q.push_back({i == int'(len), bd[i]});
`ifdef AES_AXIM_RLAST_CHECK_EN
                if (i == int'(len) && !bl[i]) e = 1'b1;
                if (i < int'(len) && bl[i]) begin
                    e = 1'b1;
                    break;
                end
`endif
            end
        end
        exp_done_q.push_back(e);
    endtask

    task automatic fill(input logic [7:0] len);
        for (int i = 0; i < 256; i++) begin
            bd[i] = $urandom;
            br[i] = 2'b00;
            bl[i] = (i == int'(len));
        end
        g_bresp = 2'b00;
        g_bid   = 2'b11;
    endtask

    // Issue one command; while busy keep cmd_valid high with junk fields so a
    // wrongly accepted second command would show up as an unexpected burst.
    task automatic issue(input logic wr, input logic [5:0] addr, input logic [7:0] len,
                         input bit wait_done);
        int n;
        int d0;
        model(wr, addr, len);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 200);
        if (!cmd_ready) begin
            chk("cmd_accept_timeout", 64'(cmd_ready), 64'(1));
            cmd_valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        d0 = done_cnt;
        @(posedge clk); #1;
        if (wait_done) begin
            cmd_write = 1'($urandom); cmd_addr = 6'($urandom); cmd_len = 8'($urandom);
            n = 0;
            while (done_cnt == d0 && n < 5000) begin
                @(posedge clk);
                n++;
            end
            #1 cmd_valid = 1'b0;
            chk("done_timeout", 64'(done_cnt != d0), 64'(1));
        end else begin
            cmd_valid = 1'b0;
        end
    endtask

    // Slave / source / sink driver: handshakes sampled at negedge, drives updated after posedge.
    initial begin
        logic s_src, s_wl, s_b, s_ar, s_r, b_pend, r_act;
        b_pend = 1'b0; r_act = 1'b0;
        forever begin
            @(negedge clk);
            s_src = wr_valid && wr_ready;
            s_wl  = wvalid && wready && wlast;
            s_b   = bvalid && bready;
            s_ar  = arvalid && arready;
            s_r   = rvalid && rready;
            @(posedge clk); #1;
            if (!rst_n) begin
                awready = 0; arready = 0; wready = 0; wr_valid = 0; bvalid = 0;
                rvalid = 0; rd_ready = 0; b_pend = 0; r_act = 0;
                continue;
            end
            if (s_src && src_q.size() > 0) void'(src_q.pop_front());
            if (s_wl) b_pend = 1'b1;
            if (s_b) begin
                if (b_q.size() > 0) void'(b_q.pop_front());
                b_pend = 1'b0;
            end
            if (s_ar) r_act = 1'b1;
            if (s_r) begin
                if (r_q.size() > 0) void'(r_q.pop_front());
                if (r_q.size() == 0) r_act = 1'b0;
            end
            awready  = 1'($urandom);
            arready  = 1'($urandom);
            wready   = ($urandom % 3) != 0;
            rd_ready = 1'($urandom);
            if (!(wr_valid && !s_src)) wr_valid = (src_q.size() > 0) && 1'($urandom);
            wr_data = (src_q.size() > 0) ? src_q[0] : $urandom;
            if (!(bvalid && !s_b)) bvalid = b_pend && (b_q.size() > 0) && 1'($urandom);
            {bid, bresp} = (b_q.size() > 0) ? b_q[0] : 4'h0;
            if (!(rvalid && !s_r)) rvalid = r_act && (r_q.size() > 0) && 1'($urandom);
            {rlast, rresp, rdata} = (r_q.size() > 0) ? r_q[0] : 35'h0;
        end
    end

    // Monitor: compares every DUT-side event against the scoreboard queues.
    initial begin
        logic aw_done, prev_av;
        logic [14:0] ea;
        logic [32:0] ew;
        aw_done = 1'b0; prev_av = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                aw_done = 1'b0; prev_av = 1'b0;
                continue;
            end
            if ((awvalid || arvalid) && !prev_av)
                chk("addr_valid_latency", 64'(cyc), 64'(acc_cyc + 1));
            prev_av = awvalid || arvalid;
            if (wvalid) chk("wvalid_before_aw", 64'(aw_done), 64'(1));
            if ((awvalid && awready) || (arvalid && arready)) begin
                if (exp_a_q.size() == 0) chk("unexpected_addr", 64'(1), 64'(0));
                else begin
                    ea = exp_a_q.pop_front();
                    if (awvalid) begin
                        chk("aw_fields", {awvalid, awaddr, awlen, awsize, awburst, awid},
                            {ea[14], ea[13:0], 3'b010, 2'b01, 2'b11});
                        aw_done = 1'b1;
                    end else
                        chk("ar_fields", {~arvalid, araddr, arlen, arsize, arburst},
                            {ea[14], ea[13:0], 3'b010, 2'b01});
                end
            end
            if (wvalid && wready) begin
                w_seen++;
                if (exp_w_q.size() == 0) chk("unexpected_wbeat", 64'(1), 64'(0));
                else begin
                    ew = exp_w_q.pop_front();
                    chk("wbeat", {wstrb, wlast, wdata}, {4'hF, ew});
                end
            end
            if (rd_valid && rd_ready) begin
                if (exp_rd_q.size() == 0) chk("unexpected_rdbeat", 64'(1), 64'(0));
                else chk("rdbeat", {rd_last, rd_data}, exp_rd_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                if (exp_done_q.size() == 0) chk("unexpected_done", 64'(1), 64'(0));
                else chk("done_err", 64'(err), 64'(exp_done_q.pop_front()));
                chk("done_latency", 64'(cyc), 64'(last_hs + 1));
                aw_done = 1'b0;
            end
            if ((bvalid && bready) || (rvalid && rready)) last_hs = cyc;
        end
    end

    initial begin
        int n, w0;
        #1;
        chk("reset_outputs", {cmd_ready, awvalid, wvalid, wr_ready, bready, arvalid, rready,
                              rd_valid, done, err}, 64'(0));
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("cmd_ready_held_after_release", 64'(cmd_ready), 64'(0));
        @(posedge clk); #1 chk("cmd_ready_first_clock", 64'(cmd_ready), 64'(1));

        fill(8'd0); bd[0] = 32'hFFFFFFFF;
        issue(1'b1, 6'h04, 8'd0, 1);
        fill(8'd3); bd[0] = 32'hABABABAB; bd[1] = 32'hCDCDCDCD; bd[2] = 32'hEFEFEFEF; bd[3] = 32'h01010101;
        issue(1'b1, 6'h08, 8'd3, 1);
        fill(8'd3);
        issue(1'b0, 6'h04, 8'd3, 1);
        fill(8'd2); g_bresp = 2'b10;
        issue(1'b1, 6'h10, 8'd2, 1);
        fill(8'd1);
        issue(1'b0, 6'h0C, 8'd1, 1);
        fill(8'd1); g_bid = 2'b01;
        issue(1'b1, 6'h20, 8'd1, 1);
        fill(8'd3); bl[1] = 1'b1;
        issue(1'b0, 6'h00, 8'd3, 1);
        fill(8'd2); bl[2] = 1'b0;
        issue(1'b0, 6'h14, 8'd2, 1);
        fill(8'd1); br[0] = 2'b10;
        issue(1'b0, 6'h18, 8'd1, 1);
        fill(8'd255);
        issue(1'b1, 6'h3C, 8'd255, 1);
        fill(8'd255);
        issue(1'b0, 6'h00, 8'd255, 1);

        for (int k = 0; k < 30; k++) begin
            logic [7:0] ln;
            ln = 8'($urandom_range(0, 15));
            fill(ln);
            for (int i = 0; i <= int'(ln); i++) begin
                if ($urandom % 8 == 0) br[i] = 2'b10;
                if ($urandom % 10 == 0) bl[i] = ~bl[i];
            end
            if ($urandom % 6 == 0) g_bresp = 2'b10;
            if ($urandom % 8 == 0) g_bid = 2'($urandom);
            issue(1'($urandom), {4'($urandom), 2'b00}, ln, 1);
        end

        // Reset in the middle of a 4-beat write: everything drops, no completion.
        fill(8'd3);
        w0 = w_seen;
        issue(1'b1, 6'h08, 8'd3, 0);
        n = 0;
        while (w_seen == w0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk("reset_test_first_beat", 64'(w_seen != w0), 64'(1));
        @(negedge clk); #2 rst_n = 1'b0;
        #1 chk("midburst_reset_outputs", {cmd_ready, awvalid, wvalid, wr_ready, bready, arvalid,
                                          rready, rd_valid, done, err}, 64'(0));
        exp_a_q.delete(); exp_w_q.delete(); exp_rd_q.delete(); exp_done_q.delete();
        src_q.delete(); b_q.delete(); r_q.delete();
        n = done_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("cmd_ready_low_at_release", 64'(cmd_ready), 64'(0));
        @(posedge clk); #1 chk("cmd_ready_after_release", 64'(cmd_ready), 64'(1));
        chk("no_done_after_reset", 64'(done_cnt), 64'(n));
        fill(8'd2);
        issue(1'b0, 6'h24, 8'd2, 1);

        repeat (5) @(posedge clk);
        chk("queues_drained", 64'(exp_a_q.size() + exp_w_q.size() + exp_rd_q.size() +
                                  exp_done_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
